// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_pkg
//  Description : Decoded control bundle, operand/immediate selectors, ALU
//                opcodes and the execute-stage result record.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

    localparam int EXEC_XLEN = 32;

    // Encodings 10-15 are reserved and evaluate to zero in the ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } b_sel_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       regwen;
        imm_sel_e   imm_sel;
        a_sel_e     A_sel;
        b_sel_e     B_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } control_signals_t;

    typedef struct packed {
        logic [EXEC_XLEN-1:0] result;
        logic [4:0]           rd;
        logic                 regwen;
    } exec_result_t;

endpackage
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
//  Module      : exec_alu
//  Description : Purely combinational integer ALU shared by execute and later
//                stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_alu
    import control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          alu_op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_lt_signed;
    logic               w_lt_unsigned;

    assign w_shamt       = b[SHAMT_W-1:0];
    assign w_lt_signed   = $signed(a) < $signed(b);
    assign w_lt_unsigned = a < b;

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << w_shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, w_lt_signed};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $signed(a) >>> w_shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : Immediate generation, operand select with EX->EX bypass, ALU
//                and a valid/ready result register toward writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
    import control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  control_signals_t in_ctrl,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic             out_regwen
);

    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_fwd_rs1;
    logic            w_fwd_rs2;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_capture;
    logic            w_unused_opcode;

    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd;
    logic            r_regwen;

    // The opcode field carries no immediate bits.
    assign w_unused_opcode = ^in_instr[6:0];

    always_comb begin
        w_imm32 = '0;
        case (in_ctrl.imm_sel)
            IMM_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            IMM_U: w_imm32 = {in_instr[31:12], 12'b0};
            IMM_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    // Bypass the registered result to the instruction now sitting in decode.
    assign w_fwd_rs1 = r_valid && r_regwen && (r_rd != 5'd0) && (r_rd == in_ctrl.rs1);
    assign w_fwd_rs2 = r_valid && r_regwen && (r_rd != 5'd0) && (r_rd == in_ctrl.rs2);
    assign w_rs1     = w_fwd_rs1 ? r_result : in_rs1_data;
    assign w_rs2     = w_fwd_rs2 ? r_result : in_rs2_data;

    always_comb begin
        w_op_a = '0;
        case (in_ctrl.A_sel)
            SRC_A_RS1:  w_op_a = w_rs1;
            SRC_A_PC:   w_op_a = in_pc;
            SRC_A_ZERO: w_op_a = '0;
            default:    w_op_a = '0;
        endcase
    end

    always_comb begin
        w_op_b = '0;
        case (in_ctrl.B_sel)
            SRC_B_RS2:  w_op_b = w_rs2;
            SRC_B_IMM:  w_op_b = w_imm;
            SRC_B_FOUR: w_op_b = XLEN'(4);
            default:    w_op_b = '0;
        endcase
    end

    exec_alu #(
        .XLEN   (XLEN)
    ) u_exec_alu (
        .alu_op (in_ctrl.alu_op),
        .a      (w_op_a),
        .b      (w_op_b),
        .result (w_alu_result)
    );

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
            r_regwen <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid  <= 1'b1;
            r_result <= w_alu_result;
            r_rd     <= in_ctrl.rd;
            r_regwen <= in_ctrl.regwen && (in_ctrl.rd != 5'd0);
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_rd     = r_rd;
    assign out_regwen = r_regwen;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Scoreboard bench for execute_stage: handshake, bypass,
//                backpressure, ALU corners, immediates, flush and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;
    import control_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    control_signals_t in_ctrl;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic [31:0]      in_rs1_data;
    logic [31:0]      in_rs2_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [4:0]       out_rd;
    logic             out_regwen;

    int checks = 0;
    int errors = 0;
    exec_result_t sb[$];
    exec_result_t exp;
    exec_result_t got;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_regwen  (out_regwen)
    );

    assign got = '{result: out_result, rd: out_rd, regwen: out_regwen};

    function automatic control_signals_t mk(alu_op_e op, imm_sel_e isel, a_sel_e asel,
                                            b_sel_e bsel, logic [4:0] rs1, logic [4:0] rs2,
                                            logic [4:0] rd, logic we);
        control_signals_t c;
        c.alu_op = op; c.regwen = we; c.imm_sel = isel; c.A_sel = asel; c.B_sel = bsel;
        c.rs1 = rs1; c.rs2 = rs2; c.rd = rd;
        return c;
    endfunction

    task automatic drive(input control_signals_t c, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1; in_ctrl = c; in_instr = instr; in_pc = pc;
        in_rs1_data = r1; in_rs2_data = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        tick(); tick();
        checks++;
        if ({out_valid, out_result, out_rd, out_regwen} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b %h, expected v=0 all zero", out_valid, got);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, expected 1", in_ready);
        end
    endtask

    task automatic test_addi();
        drive(mk(ALU_ADD, IMM_I, SRC_A_RS1, SRC_B_IMM, 5'd0, 5'd5, 5'd1, 1'b1),
              32'h00500093, 32'h0, 32'h0, 32'h0);
        sb.push_back('{result: 32'd5, rd: 5'd1, regwen: 1'b1});
        tick();
        in_valid = 1'b0;
        exp = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL addi: got v=%0b %h, expected v=1 %h", out_valid, got, exp);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain: got v=%0b, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1 [5] = '{32'd0, 32'd0, 32'd0, 32'd3, 32'd100};
        logic [31:0] r2 [5] = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd0};
        control_signals_t c [5];
        logic [31:0] ins [5] = '{32'h00500093, 32'h00108133, 32'h00700013, 32'h000001B3, 32'h00328233};
        exec_result_t e [5];
        c[0] = mk(ALU_ADD, IMM_I,    SRC_A_RS1, SRC_B_IMM, 5'd0, 5'd5, 5'd1, 1'b1);
        c[1] = mk(ALU_ADD, IMM_NONE, SRC_A_RS1, SRC_B_RS2, 5'd1, 5'd1, 5'd2, 1'b1);
        c[2] = mk(ALU_ADD, IMM_I,    SRC_A_RS1, SRC_B_IMM, 5'd0, 5'd7, 5'd0, 1'b1);
        c[3] = mk(ALU_ADD, IMM_NONE, SRC_A_RS1, SRC_B_RS2, 5'd0, 5'd0, 5'd3, 1'b1);
        c[4] = mk(ALU_ADD, IMM_NONE, SRC_A_RS1, SRC_B_RS2, 5'd5, 5'd3, 5'd4, 1'b1);
        e[0] = '{result: 32'd5,   rd: 5'd1, regwen: 1'b1};
        e[1] = '{result: 32'd10,  rd: 5'd2, regwen: 1'b1};
        e[2] = '{result: 32'd7,   rd: 5'd0, regwen: 1'b0};
        e[3] = '{result: 32'd7,   rd: 5'd3, regwen: 1'b1};
        e[4] = '{result: 32'd107, rd: 5'd4, regwen: 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(c[i], ins[i], 32'h0, r1[i], r2[i]);
            sb.push_back(e[i]);
            tick();
            exp = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got v=%0b %h, expected v=1 %h", i, out_valid, got, exp);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        exec_result_t held;
        out_ready = 1'b1;
        drive(mk(ALU_ADD, IMM_I, SRC_A_RS1, SRC_B_IMM, 5'd0, 5'd5, 5'd1, 1'b1),
              32'h00500093, 32'h0, 32'h0, 32'h0);
        sb.push_back('{result: 32'd5, rd: 5'd1, regwen: 1'b1});
        tick();
        held = sb[0];
        out_ready = 1'b0;
        drive(mk(ALU_ADD, IMM_I, SRC_A_RS1, SRC_B_IMM, 5'd0, 5'd10, 5'd6, 1'b1),
              32'h00A00313, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready[%0d]: got %0b, expected 0", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || got !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%0b %h, expected v=1 %h", i, out_valid, got, held);
            end
        end
        out_ready = 1'b1;
        #1;
        void'(sb.pop_front());
        sb.push_back('{result: 32'd10, rd: 5'd6, regwen: 1'b1});
        tick();
        in_valid = 1'b0;
        exp = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL release_capture: got v=%0b %h, expected v=1 %h", out_valid, got, exp);
        end
        tick();
    endtask

    task automatic test_alu_corners();
        alu_op_e ops [11];
        logic [31:0] a [11] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h12345678,
                                32'h1, 32'h80000000, 32'hF0, 32'hF0, 32'hF0, 32'hFFFFFFFF};
        logic [31:0] b [11] = '{32'd33, 32'd1, 32'd1, 32'd1, 32'h1, 32'd35, 32'd4,
                                32'hFF, 32'h0F, 32'h3C, 32'd2};
        logic [31:0] r [11] = '{32'hC0000000, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd8,
                                32'h08000000, 32'h0F, 32'hFF, 32'h30, 32'd1};
        ops = '{ALU_SRA, ALU_SLT, ALU_SLTU, ALU_SUB, alu_op_e'(4'd12), ALU_SLL, ALU_SRL,
                ALU_XOR, ALU_OR, ALU_AND, ALU_ADD};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(mk(ops[i], IMM_NONE, SRC_A_RS1, SRC_B_RS2, 5'd11, 5'd12, 5'd10, 1'b1),
                  32'h0, 32'h0, a[i], b[i]);
            sb.push_back('{result: r[i], rd: 5'd10, regwen: 1'b1});
            tick();
            exp = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL alu[%0d]: got v=%0b %h, expected v=1 %h", i, out_valid, got, exp);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_jal_imm();
        control_signals_t c [4];
        logic [31:0] ins [4] = '{32'h0000006F, 32'hFE000EE3, 32'h12345037, 32'hFE112C23};
        logic [31:0] r1 [4]  = '{32'h0, 32'h0, 32'h0, 32'h1000};
        exec_result_t e [4];
        c[0] = mk(ALU_ADD, IMM_J, SRC_A_PC,   SRC_B_FOUR, 5'd0, 5'd0, 5'd1, 1'b1);
        c[1] = mk(ALU_ADD, IMM_B, SRC_A_ZERO, SRC_B_IMM,  5'd0, 5'd0, 5'd5, 1'b1);
        c[2] = mk(ALU_ADD, IMM_U, SRC_A_ZERO, SRC_B_IMM,  5'd0, 5'd0, 5'd0, 1'b1);
        c[3] = mk(ALU_ADD, IMM_S, SRC_A_RS1,  SRC_B_IMM,  5'd2, 5'd1, 5'd24, 1'b0);
        e[0] = '{result: 32'h104,      rd: 5'd1,  regwen: 1'b1};
        e[1] = '{result: 32'hFFFFFFFC, rd: 5'd5,  regwen: 1'b1};
        e[2] = '{result: 32'h12345000, rd: 5'd0,  regwen: 1'b0};
        e[3] = '{result: 32'h00000FF8, rd: 5'd24, regwen: 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(c[i], ins[i], 32'h100, r1[i], 32'h0);
            sb.push_back(e[i]);
            tick();
            exp = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL jal_imm[%0d]: got v=%0b %h, expected v=1 %h", i, out_valid, got, exp);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_reset();
        control_signals_t c;
        c = mk(ALU_ADD, IMM_I, SRC_A_RS1, SRC_B_IMM, 5'd0, 5'd5, 5'd1, 1'b1);
        out_ready = 1'b1;
        drive(c, 32'h00500093, 32'h0, 32'h0, 32'h0);
        tick();
        flush = 1'b1;
        drive(c, 32'h00A00093, 32'h0, 32'h0, 32'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_input: got v=%0b, expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_late_result: got v=%0b, expected 0", out_valid);
        end
        drive(c, 32'h00500093, 32'h0, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_stalled: got v=%0b rdy=%0b, expected v=0 rdy=1", out_valid, in_ready);
        end
        drive(c, 32'h00500093, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if ({out_valid, out_result, out_rd, out_regwen} !== 39'd0) begin
            errors++;
            $display("FAIL reset_mid_stall: got v=%0b %h, expected v=0 all zero", out_valid, got);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_late_result: got v=%0b, expected 0", out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_alu_corners();
        test_jal_imm();
        test_flush_reset();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
